// File: rtl/mesm6_mem_pkg.sv
// Shared types and constants for the MESM-6 memory responder.
// Bus widths, FSM states, bus ids and access ops.
package mesm6_mem_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = 15;
  localparam int unsigned MEM_DATA_WIDTH = 48;
  localparam int unsigned WAIT_CNT_WIDTH = 4;
  localparam int unsigned MEM_WORDS      = 32'(1) << MEM_ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    DONE
  } state_e;

  typedef enum logic {
    IBUS,
    DBUS
  } bus_e;

  typedef enum logic [1:0] {
    FETCH,
    READ,
    WRITE
  } op_e;

  // A dbus request with both read and write high is a protocol error and is taken as a write.
  function automatic op_e decode_op(input bus_e bus, input logic dbus_write);
    if (bus == IBUS) begin
      return FETCH;
    end
    return dbus_write ? WRITE : READ;
  endfunction

endpackage

// File: rtl/mesm6_mem_responder_if.sv
// Core ibus/dbus request signals plus the single-port SRAM connection.
// master = core and SRAM side, slave = the responder.
interface mesm6_mem_responder_if #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter int unsigned DATA_WIDTH = 48
);

  logic                  ibus_fetch;
  logic [ADDR_WIDTH-1:0] ibus_addr;
  logic [DATA_WIDTH-1:0] ibus_input;
  logic                  ibus_done;

  logic                  dbus_read;
  logic                  dbus_write;
  logic [ADDR_WIDTH-1:0] dbus_addr;
  logic [DATA_WIDTH-1:0] dbus_output;
  logic [DATA_WIDTH-1:0] dbus_input;
  logic                  dbus_done;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output ibus_fetch, ibus_addr,
    input  ibus_input, ibus_done,
    output dbus_read, dbus_write, dbus_addr, dbus_output,
    input  dbus_input, dbus_done,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  ibus_fetch, ibus_addr,
    output ibus_input, ibus_done,
    input  dbus_read, dbus_write, dbus_addr, dbus_output,
    output dbus_input, dbus_done,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

endinterface

// File: rtl/mesm6_mem_arbiter.sv
// Round-robin grant between ibus and dbus; contention goes to the bus
// that was not granted last.
module mesm6_mem_arbiter
  import mesm6_mem_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic req_ibus,
  input  logic req_dbus,
  input  logic take,
  output bus_e grant_c,
  output logic grant_valid_c
);

  bus_e last_grant;

  always_comb begin
    grant_valid_c = req_ibus | req_dbus;
    grant_c       = last_grant;
    if (req_ibus && req_dbus) begin
      grant_c = (last_grant == DBUS) ? IBUS : DBUS;
    end else if (req_ibus) begin
      grant_c = IBUS;
    end else if (req_dbus) begin
      grant_c = DBUS;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant <= DBUS;
    end else if (take) begin
      last_grant <= grant_c;
    end
  end

endmodule

// File: rtl/mesm6_mem_responder.sv
// Target side of the MESM-6 ibus/dbus: arbitrates held requests onto one
// synchronous single-port SRAM and returns data with a one-cycle done pulse.
module mesm6_mem_responder
  import mesm6_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = MEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = MEM_DATA_WIDTH,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic                clk,
  input logic                reset_n,
  mesm6_mem_responder_if.slave bus
);

  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LAST =
    WAIT_CNT_WIDTH'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  state_e                    state_q, state_d;
  logic [WAIT_CNT_WIDTH-1:0] cnt_q, cnt_d;
  bus_e                      req_bus_q, req_bus_d;
  op_e                       req_op_q, req_op_d;
  logic [ADDR_WIDTH-1:0]     req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0]     req_wdata_q, req_wdata_d;

  logic                      mem_en_q, mem_en_d;
  logic                      mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
  logic                      ibus_done_q, ibus_done_d;
  logic                      dbus_done_q, dbus_done_d;
  logic [DATA_WIDTH-1:0]     ibus_q, ibus_q_d;
  logic [DATA_WIDTH-1:0]     dbus_q, dbus_q_d;

  bus_e                      grant_c;
  logic                      grant_valid_c;
  logic                      take_c;
  logic                      req_active_c;
  op_e                       new_op_c;
  logic [ADDR_WIDTH-1:0]     new_addr_c;

  mesm6_mem_arbiter u_arbiter (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_ibus      (bus.ibus_fetch),
    .req_dbus      (bus.dbus_read | bus.dbus_write),
    .take          (take_c),
    .grant_c       (grant_c),
    .grant_valid_c (grant_valid_c)
  );

  assign req_active_c = (req_bus_q == IBUS) ? bus.ibus_fetch
                                            : (bus.dbus_read | bus.dbus_write);
  assign new_op_c     = decode_op(grant_c, bus.dbus_write);
  assign new_addr_c   = (grant_c == IBUS) ? bus.ibus_addr : bus.dbus_addr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_bus_q   <= DBUS;
      req_op_q    <= FETCH;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ibus_done_q <= 1'b0;
      dbus_done_q <= 1'b0;
      ibus_q      <= '0;
      dbus_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_bus_q   <= req_bus_d;
      req_op_q    <= req_op_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ibus_done_q <= ibus_done_d;
      dbus_done_q <= dbus_done_d;
      ibus_q      <= ibus_q_d;
      dbus_q      <= dbus_q_d;
    end
  end

  // Next-state logic; SRAM strobes and done pulses are computed one cycle
  // ahead so they come straight from flops in ACCESS and DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_bus_d   = req_bus_q;
    req_op_d    = req_op_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ibus_done_d = 1'b0;
    dbus_done_d = 1'b0;
    ibus_q_d    = ibus_q;
    dbus_q_d    = dbus_q;
    take_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_valid_c) begin
          take_c      = 1'b1;
          req_bus_d   = grant_c;
          req_op_d    = new_op_c;
          req_addr_d  = new_addr_c;
          req_wdata_d = bus.dbus_output;
          cnt_d       = '0;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
          end else begin
            state_d     = ACCESS;
            mem_en_d    = 1'b1;
            mem_we_d    = (new_op_c == WRITE);
            mem_addr_d  = new_addr_c;
            mem_wdata_d = bus.dbus_output;
          end
        end
      end

      WAIT: begin
        if (!req_active_c) begin
          state_d = IDLE;
        end else if (cnt_q == WAIT_LAST) begin
          state_d     = ACCESS;
          mem_en_d    = 1'b1;
          mem_we_d    = (req_op_q == WRITE);
          mem_addr_d  = req_addr_q;
          mem_wdata_d = req_wdata_q;
        end else begin
          cnt_d = cnt_q + WAIT_CNT_WIDTH'(1);
        end
      end

      ACCESS: begin
        state_d     = DONE;
        ibus_done_d = (req_bus_q == IBUS);
        dbus_done_d = (req_bus_q == DBUS);
      end

      DONE: begin
        state_d = IDLE;
        if (req_op_q != WRITE) begin
          if (req_bus_q == IBUS) begin
            ibus_q_d = bus.mem_rdata;
          end else begin
            dbus_q_d = bus.mem_rdata;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Read data passes straight through in DONE, otherwise the holding registers.
  always_comb begin
    bus.ibus_input = ibus_q;
    bus.dbus_input = dbus_q;
    if (state_q == DONE && req_op_q != WRITE) begin
      if (req_bus_q == IBUS) begin
        bus.ibus_input = bus.mem_rdata;
      end else begin
        bus.dbus_input = bus.mem_rdata;
      end
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.ibus_done = ibus_done_q;
  assign bus.dbus_done = dbus_done_q;

endmodule

// File: tb/tb_mesm6_mem_responder.sv
// Scoreboard bench for mesm6_mem_responder: one instance without wait states,
// one with three, each backed by a small behavioural SRAM.
module tb_mesm6_mem_responder;
  import mesm6_mem_pkg::*;

  typedef struct {
    bit          dbus;
    bit          rd;
    logic [47:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst0 = 1'b0;
  logic rst3 = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q3[$];

  logic [47:0] wd0 [MEM_WORDS];
  bit          wv0 [MEM_WORDS];
  logic [47:0] wd3 [MEM_WORDS];
  bit          wv3 [MEM_WORDS];

  mesm6_mem_responder_if #(.ADDR_WIDTH(15), .DATA_WIDTH(48)) b0 ();
  mesm6_mem_responder_if #(.ADDR_WIDTH(15), .DATA_WIDTH(48)) b3 ();

  mesm6_mem_responder #(.WAIT_STATES(0)) dut0 (.clk(clk), .reset_n(rst0), .bus(b0.slave));
  mesm6_mem_responder #(.WAIT_STATES(3)) dut3 (.clk(clk), .reset_n(rst3), .bus(b3.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [47:0] pat(input logic [14:0] a);
    return 48'hC0DE_0000_0000 | 48'(a);
  endfunction

  // Synchronous SRAMs: unwritten words read back as pat(addr).
  always @(posedge clk) begin
    if (b0.mem_en) begin
      if (b0.mem_we) begin
        wd0[b0.mem_addr] <= b0.mem_wdata;
        wv0[b0.mem_addr] <= 1'b1;
      end else begin
        b0.mem_rdata <= wv0[b0.mem_addr] ? wd0[b0.mem_addr] : pat(b0.mem_addr);
      end
    end
    if (b3.mem_en) begin
      if (b3.mem_we) begin
        wd3[b3.mem_addr] <= b3.mem_wdata;
        wv3[b3.mem_addr] <= 1'b1;
      end else begin
        b3.mem_rdata <= wv3[b3.mem_addr] ? wd3[b3.mem_addr] : pat(b3.mem_addr);
      end
    end
  end

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitors: every done pulse pops one expectation.
  always @(negedge clk) begin : mon0
    exp_t e;
    if (b0.ibus_done || b0.dbus_done) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut0_unexpected_done actual=cycle %0d required=no done", cyc);
      end else begin
        e = q0.pop_front();
        chk("dut0_done_bus", 48'(b0.dbus_done), 48'(e.dbus));
        chk("dut0_done_cycle", 48'(cyc), 48'(e.cyc));
        if (e.rd) chk("dut0_rdata", e.dbus ? b0.dbus_input : b0.ibus_input, e.data);
      end
    end
  end

  always @(negedge clk) begin : mon3
    exp_t e;
    if (b3.ibus_done || b3.dbus_done) begin
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut3_unexpected_done actual=cycle %0d required=no done", cyc);
      end else begin
        e = q3.pop_front();
        chk("dut3_done_bus", 48'(b3.dbus_done), 48'(e.dbus));
        chk("dut3_done_cycle", 48'(cyc), 48'(e.cyc));
        if (e.rd) chk("dut3_rdata", e.dbus ? b3.dbus_input : b3.ibus_input, e.data);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push0(input bit dbus, input bit rd, input logic [47:0] data, input int c);
    exp_t e;
    e.dbus = dbus; e.rd = rd; e.data = data; e.cyc = c;
    q0.push_back(e);
  endtask

  task automatic d_go(input logic rd, input logic wr, input logic [14:0] a, input logic [47:0] d);
    b0.dbus_read = rd; b0.dbus_write = wr; b0.dbus_addr = a; b0.dbus_output = d;
  endtask

  task automatic i_go(input logic [14:0] a);
    b0.ibus_fetch = 1'b1; b0.ibus_addr = a;
  endtask

  task automatic d_wait_drop(input string name);
    bit got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = b0.dbus_done;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no dbus_done required=dbus_done", name);
    end
    step(1);
    b0.dbus_read = 1'b0; b0.dbus_write = 1'b0;
  endtask

  task automatic i_wait_drop(input string name);
    bit got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got = b0.ibus_done;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no ibus_done required=ibus_done", name);
    end
    step(1);
    b0.ibus_fetch = 1'b0;
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    int en_seen;
    exp_t e;
    logic [47:0] d1, d6;
    d1 = 48'h123456789ABC;
    d6 = 48'hFEDC_BA98_7654;
    b0.ibus_fetch = 0; b0.ibus_addr = 0; b0.dbus_read = 0; b0.dbus_write = 0;
    b0.dbus_addr = 0; b0.dbus_output = 0;
    b3.ibus_fetch = 0; b3.ibus_addr = 0; b3.dbus_read = 0; b3.dbus_write = 0;
    b3.dbus_addr = 0; b3.dbus_output = 0;

    // Reset state
    step(3);
    @(negedge clk);
    chk("rst_ibus_done", 48'(b0.ibus_done), 48'd0);
    chk("rst_dbus_done", 48'(b0.dbus_done), 48'd0);
    chk("rst_mem_en", 48'(b0.mem_en), 48'd0);
    chk("rst_mem_we", 48'(b0.mem_we), 48'd0);
    chk("rst_ibus_input", b0.ibus_input, 48'd0);
    chk("rst_dbus_input", b0.dbus_input, 48'd0);
    step(1);
    rst0 = 1'b1; rst3 = 1'b1;
    step(2);

    // Write then read back address 0o12345
    n = cyc;
    push0(1, 0, 48'd0, n + 2);
    d_go(0, 1, 15'o12345, d1);
    @(negedge clk);
    chk("wr_mem_en_n", 48'(b0.mem_en), 48'd0);
    @(negedge clk);
    chk("wr_mem_en_n1", 48'(b0.mem_en), 48'd1);
    chk("wr_mem_we_n1", 48'(b0.mem_we), 48'd1);
    chk("wr_mem_addr", 48'(b0.mem_addr), 48'(15'o12345));
    chk("wr_mem_wdata", b0.mem_wdata, d1);
    d_wait_drop("wr1");
    n = cyc;
    push0(1, 1, d1, n + 2);
    d_go(1, 0, 15'o12345, 48'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rd_mem_we_n1", 48'(b0.mem_we), 48'd0);
    d_wait_drop("rd1");
    @(negedge clk);
    chk("rd1_dbus_hold", b0.dbus_input, d1);

    // Simultaneous fetch 0 and read 5 after reset: IBUS first
    step(1);
    n = cyc;
    push0(0, 1, pat(15'd0), n + 2);
    push0(1, 1, pat(15'd5), n + 5);
    i_go(15'd0);
    d_go(1, 0, 15'd5, 48'd0);
    fork
      i_wait_drop("pair_i");
      d_wait_drop("pair_d");
    join
    @(negedge clk);
    chk("pair_ibus_hold", b0.ibus_input, pat(15'd0));

    // Lone fetch leaves last_grant=IBUS, so the next pair goes to DBUS first
    step(1);
    n = cyc;
    push0(0, 1, pat(15'd9), n + 2);
    i_go(15'd9);
    i_wait_drop("lone_i");
    n = cyc;
    push0(1, 1, pat(15'd11), n + 2);
    push0(0, 1, pat(15'd10), n + 5);
    i_go(15'd10);
    d_go(1, 0, 15'd11, 48'd0);
    fork
      i_wait_drop("pair2_i");
      d_wait_drop("pair2_d");
    join

    // Back-to-back held fetches 100 then 101
    n = cyc;
    push0(0, 1, pat(15'd100), n + 2);
    push0(0, 1, pat(15'd101), n + 5);
    i_go(15'd100);
    for (int k = 0; k < 3; k++) @(negedge clk);
    step(1);
    b0.ibus_addr = 15'd101;
    @(negedge clk);
    chk("b2b_hold_n3", b0.ibus_input, pat(15'd100));
    @(negedge clk);
    chk("b2b_hold_n4", b0.ibus_input, pat(15'd100));
    i_wait_drop("b2b");

    // Read and write both high: performed as a write, dbus_q untouched
    n = cyc;
    push0(1, 0, 48'd0, n + 2);
    d_go(1, 1, 15'd3, d6);
    @(negedge clk);
    @(negedge clk);
    chk("rw_mem_we", 48'(b0.mem_we), 48'd1);
    @(negedge clk);
    chk("rw_dbus_input_done", b0.dbus_input, pat(15'd11));
    step(1);
    b0.dbus_read = 1'b0; b0.dbus_write = 1'b0;
    @(negedge clk);
    chk("rw_dbus_q_kept", b0.dbus_input, pat(15'd11));
    chk("rw_sram_written", wv0[3] ? wd0[3] : 48'hX, d6);

    // Top address 32767 reads back as-is
    step(1);
    n = cyc;
    push0(1, 1, pat(15'd32767), n + 2);
    d_go(1, 0, 15'd32767, 48'd0);
    d_wait_drop("top_addr");

    // Reset during ACCESS of a read
    n = cyc;
    d_go(1, 0, 15'd20, 48'd0);
    step(1);
    rst0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstacc_dbus_done", 48'(b0.dbus_done), 48'd0);
    chk("rstacc_ibus_input", b0.ibus_input, 48'd0);
    chk("rstacc_dbus_input", b0.dbus_input, 48'd0);
    chk("rstacc_state", 48'(dut0.state_q), 48'(IDLE));
    step(1);
    b0.dbus_read = 1'b0;
    step(1);
    rst0 = 1'b1;
    step(2);
    n = cyc;
    push0(1, 1, d6, n + 2);
    d_go(1, 0, 15'd3, 48'd0);
    d_wait_drop("post_rst_rd");

    // Three wait states: mem_en only at N+4, done at N+5
    step(1);
    n = cyc;
    e.dbus = 1; e.rd = 1; e.data = pat(15'd7); e.cyc = n + 5;
    q3.push_back(e);
    b3.dbus_read = 1'b1; b3.dbus_addr = 15'd7;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("ws3_mem_en_n%0d", k), 48'(b3.mem_en), 48'(k == 4));
    end
    step(1);
    b3.dbus_read = 1'b0;
    step(2);

    // Abort in WAIT: drop at N+2, no SRAM access, no done
    n = cyc;
    en_seen = 0;
    b3.dbus_read = 1'b1; b3.dbus_addr = 15'd8;
    step(2);
    b3.dbus_read = 1'b0;
    @(negedge clk);
    if (b3.mem_en) en_seen++;
    @(negedge clk);
    chk("abort_state", 48'(dut3.state_q), 48'(IDLE));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (b3.mem_en) en_seen++;
    end
    chk("abort_mem_en_count", 48'(en_seen), 48'd0);

    step(3);
    chk("q0_drained", 48'(q0.size()), 48'd0);
    chk("q3_drained", 48'(q3.size()), 48'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
